// File: rtl/fp_issue_scoreboard_if.sv
// ID-stage issue bus between the decode stage and the FP issue scoreboard.
// Register specifiers follow the pipeline convention that bit 0 is the MSB.
interface fp_issue_scoreboard_if;
  logic        id_valid;
  logic        id_fp_op;
  logic        id_f_reg_wr;
  logic        id_rs_fp;
  logic        id_rt_fp;
  logic [0:4]  id_rs;
  logic [0:4]  id_rt;
  logic [0:4]  id_rd;
  logic        stall_fp;
  logic        issue;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] pending;
  logic [3:0]  in_flight;

  modport master (
    output id_valid, id_fp_op, id_f_reg_wr, id_rs_fp, id_rt_fp, id_rs, id_rt, id_rd,
    input  stall_fp, issue, wb_valid, wb_rd, pending, in_flight
  );

  modport slave (
    input  id_valid, id_fp_op, id_f_reg_wr, id_rs_fp, id_rt_fp, id_rs, id_rt, id_rd,
    output stall_fp, issue, wb_valid, wb_rd, pending, in_flight
  );
endinterface

// File: rtl/fp_issue_scoreboard.sv
// FP issue scoreboard: a shift-pipe of FPU_LAT reservation slots tracks FPU
// results in flight; slot k writes back in k cycles. ID is stalled on RAW,
// WAW and FP write-port collisions.
// Optional build macro FP_SCOREBOARD_WB_FORWARD_EN: when defined, the slot
// writing back this cycle is ignored by the RAW/WAW checks because the
// register file (or external forwarding) supplies that value in time.
module fp_issue_scoreboard #(
  parameter int FPU_LAT = 4
) (
  input logic                  clk,
  input logic                  reset,
  fp_issue_scoreboard_if.slave sb
);

  localparam logic [3:0] LatCnt = 4'(FPU_LAT);

  logic [FPU_LAT-1:0]      v_q, v_d;
  logic [FPU_LAT-1:0][4:0] rd_q, rd_d;
  logic [3:0]              in_flight_q, in_flight_d;

  logic [31:0] pend_all;
  logic [31:0] pend_chk;
  logic        raw_hz, waw_hz, port_hz;
  logic        stall, issue, fpu_issue;

  // Decode reservation slots into per-register pending masks
  always_comb begin
    pend_all = '0;
    pend_chk = '0;
    for (int k = 0; k < FPU_LAT; k++) begin
      if (v_q[k]) begin
        pend_all[rd_q[k]] = 1'b1;
`ifdef FP_SCOREBOARD_WB_FORWARD_EN
        if (k != 0) pend_chk[rd_q[k]] = 1'b1;
`else
        pend_chk[rd_q[k]] = 1'b1;
`endif
      end
    end
  end

  // Hazard detection and issue decision
  always_comb begin
    raw_hz    = (sb.id_rs_fp && pend_chk[sb.id_rs]) ||
                (sb.id_rt_fp && pend_chk[sb.id_rt]);
    waw_hz    = sb.id_f_reg_wr && pend_chk[sb.id_rd];
    // A non-FPU FP write lands one cycle after issue, i.e. on slot 1's port cycle
    port_hz   = sb.id_f_reg_wr && !sb.id_fp_op && v_q[1];
    stall     = sb.id_valid && (raw_hz || waw_hz || port_hz);
    issue     = sb.id_valid && !stall;
    fpu_issue = issue && sb.id_fp_op;
  end

  // Next-state: shift the reservation pipe and track the in-flight count
  always_comb begin
    v_d  = '0;
    rd_d = '0;
    for (int k = 0; k < FPU_LAT - 1; k++) begin
      v_d[k]  = v_q[k+1];
      rd_d[k] = rd_q[k+1];
    end
    v_d[FPU_LAT-1]  = fpu_issue;
    rd_d[FPU_LAT-1] = fpu_issue ? 5'(sb.id_rd) : 5'd0;

    in_flight_d = in_flight_q;
    if (fpu_issue && !v_q[0]) begin
      if (in_flight_q < LatCnt) in_flight_d = in_flight_q + 4'd1;
    end else if (!fpu_issue && v_q[0]) begin
      if (in_flight_q != 4'd0) in_flight_d = in_flight_q - 4'd1;
    end
  end

  // State registers; reset discards all reservations
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q         <= '0;
      rd_q        <= '0;
      in_flight_q <= '0;
    end else begin
      v_q         <= v_d;
      rd_q        <= rd_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign sb.stall_fp  = stall;
  assign sb.issue     = issue;
  assign sb.wb_valid  = v_q[0];
  assign sb.wb_rd     = rd_q[0];
  assign sb.pending   = pend_all;
  assign sb.in_flight = in_flight_q;

endmodule

// File: tb/tb_fp_issue_scoreboard.sv
// Bench for fp_issue_scoreboard: directed vector table, reset sequence and
// randomized traffic against a queue-based reference model.
module tb_fp_issue_scoreboard;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_issue_scoreboard_if sb_if ();

  fp_issue_scoreboard #(.FPU_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  typedef struct {
    logic        v, fp, fwr, rsf, rtf;
    logic [4:0]  rs, rt, rd;
    logic        e_stall, e_issue, e_wbv;
    logic [4:0]  e_wbrd;
    logic [3:0]  e_if;
    logic [31:0] e_pend;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: each outstanding FPU op with its cycles-to-writeback
  int         q_rem[$];
  logic [4:0] q_rd[$];

  logic        m_stall, m_issue, m_wbv;
  logic [4:0]  m_wbrd;
  logic [3:0]  m_if;
  logic [31:0] m_pend;

  function automatic vec_t mk(input logic v, fp, fwr, rsf, rtf,
                              input int rs, rt, rd,
                              input logic st, is, wbv, input int wbrd, inf,
                              input logic [31:0] pend);
    vec_t x;
    x.v = v; x.fp = fp; x.fwr = fwr; x.rsf = rsf; x.rtf = rtf;
    x.rs = 5'(rs); x.rt = 5'(rt); x.rd = 5'(rd);
    x.e_stall = st; x.e_issue = is; x.e_wbv = wbv;
    x.e_wbrd = 5'(wbrd); x.e_if = 4'(inf); x.e_pend = pend;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    sb_if.id_valid    = x.v;
    sb_if.id_fp_op    = x.fp;
    sb_if.id_f_reg_wr = x.fwr;
    sb_if.id_rs_fp    = x.rsf;
    sb_if.id_rt_fp    = x.rtf;
    sb_if.id_rs       = x.rs;
    sb_if.id_rt       = x.rt;
    sb_if.id_rd       = x.rd;
  endtask

  task automatic model_eval();
    logic [31:0] chk_set;
    bit s1, hz;
    if (!reset) begin
      q_rem.delete();
      q_rd.delete();
    end
    m_pend = '0; chk_set = '0; s1 = 0; m_wbv = 0; m_wbrd = '0;
    foreach (q_rem[i]) begin
      m_pend[q_rd[i]] = 1'b1;
      if (q_rem[i] == 0) begin m_wbv = 1'b1; m_wbrd = q_rd[i]; end
      if (q_rem[i] == 1) s1 = 1'b1;
`ifdef FP_SCOREBOARD_WB_FORWARD_EN
      if (q_rem[i] != 0) chk_set[q_rd[i]] = 1'b1;
`else
      chk_set[q_rd[i]] = 1'b1;
`endif
    end
    m_if = 4'(q_rem.size());
    hz = (sb_if.id_rs_fp && chk_set[sb_if.id_rs]) ||
         (sb_if.id_rt_fp && chk_set[sb_if.id_rt]) ||
         (sb_if.id_f_reg_wr && chk_set[sb_if.id_rd]) ||
         (sb_if.id_f_reg_wr && !sb_if.id_fp_op && s1);
    m_stall = sb_if.id_valid && hz;
    m_issue = sb_if.id_valid && !hz;
  endtask

  task automatic model_advance();
    if (!reset) return;
    foreach (q_rem[i]) q_rem[i] = q_rem[i] - 1;
    while (q_rem.size() > 0 && q_rem[0] < 0) begin
      void'(q_rem.pop_front());
      void'(q_rd.pop_front());
    end
    if (m_issue && sb_if.id_fp_op) begin
      q_rem.push_back(LAT - 1);
      q_rd.push_back(5'(sb_if.id_rd));
    end
  endtask

  task automatic run_cycle(input vec_t x, input bit use_tbl, input string tag);
    apply(x);
    @(negedge clk);
    model_eval();
    if (use_tbl) begin
      chk({tag, " stall_fp"},  32'(sb_if.stall_fp),  32'(x.e_stall));
      chk({tag, " issue"},     32'(sb_if.issue),     32'(x.e_issue));
      chk({tag, " wb_valid"},  32'(sb_if.wb_valid),  32'(x.e_wbv));
      chk({tag, " wb_rd"},     32'(sb_if.wb_rd),     32'(x.e_wbrd));
      chk({tag, " in_flight"}, 32'(sb_if.in_flight), 32'(x.e_if));
      chk({tag, " pending"},   sb_if.pending,        x.e_pend);
    end else begin
      chk({tag, " stall_fp"},  32'(sb_if.stall_fp),  32'(m_stall));
      chk({tag, " issue"},     32'(sb_if.issue),     32'(m_issue));
      chk({tag, " wb_valid"},  32'(sb_if.wb_valid),  32'(m_wbv));
      chk({tag, " wb_rd"},     32'(sb_if.wb_rd),     32'(m_wbrd));
      chk({tag, " in_flight"}, 32'(sb_if.in_flight), 32'(m_if));
      chk({tag, " pending"},   sb_if.pending,        m_pend);
    end
    @(posedge clk);
    model_advance();
    #1;
  endtask

  vec_t tbl[$];
  vec_t idle;
  vec_t x;
  logic st4, is4;

  initial begin
    idle = mk(0,0,0,0,0, 0,0,0, 0,0,0,0,0, 32'h0);
    reset = 1'b0;
    apply(idle);
    repeat (2) @(posedge clk);
    #1;
    // During reset: cleared state, issue still combinational from inputs
    apply(mk(1,1,1,1,0, 3,0,3, 0,0,0,0,0, 32'h0));
    @(negedge clk);
    chk("rst pending",   sb_if.pending,          32'h0);
    chk("rst in_flight", 32'(sb_if.in_flight),   32'h0);
    chk("rst wb_valid",  32'(sb_if.wb_valid),    32'h0);
    chk("rst wb_rd",     32'(sb_if.wb_rd),       32'h0);
    chk("rst issue",     32'(sb_if.issue),       32'h1);
    chk("rst stall_fp",  32'(sb_if.stall_fp),    32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

`ifdef FP_SCOREBOARD_WB_FORWARD_EN
    st4 = 1'b0; is4 = 1'b1;
`else
    st4 = 1'b1; is4 = 1'b0;
`endif
    //                v fp fw rsf rtf rs rt rd   st  is  wbv wbrd if  pending
    tbl.push_back(mk(1,1,1,0,0, 0,0,5,  0,  1,  0,0,0, 32'h0));
    tbl.push_back(mk(1,0,0,1,0, 5,0,0,  1,  0,  0,0,1, 32'h20));
    tbl.push_back(mk(1,0,0,1,0, 5,0,0,  1,  0,  0,0,1, 32'h20));
    tbl.push_back(mk(1,0,0,1,0, 5,0,0,  1,  0,  0,0,1, 32'h20));
    tbl.push_back(mk(1,0,0,1,0, 5,0,0,  st4,is4,1,5,1, 32'h20));
    tbl.push_back(mk(1,0,0,1,0, 5,0,0,  0,  1,  0,0,0, 32'h0));
    tbl.push_back(mk(1,1,1,0,0, 0,0,1,  0,  1,  0,0,0, 32'h0));
    tbl.push_back(mk(1,1,1,0,0, 0,0,2,  0,  1,  0,0,1, 32'h2));
    tbl.push_back(mk(1,1,1,0,0, 0,0,3,  0,  1,  0,0,2, 32'h6));
    tbl.push_back(mk(1,1,1,0,0, 0,0,4,  0,  1,  0,0,3, 32'hE));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,  0,  0,  1,1,4, 32'h1E));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,  0,  0,  1,2,3, 32'h1C));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,  0,  0,  1,3,2, 32'h18));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,  0,  0,  1,4,1, 32'h10));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,  0,  0,  0,0,0, 32'h0));
    tbl.push_back(mk(1,1,1,0,0, 0,0,7,  0,  1,  0,0,0, 32'h0));
    tbl.push_back(mk(0,0,0,1,0, 7,0,0,  0,  0,  0,0,1, 32'h80));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,  0,  0,  0,0,1, 32'h80));
    tbl.push_back(mk(1,0,1,0,0, 0,0,9,  1,  0,  0,0,1, 32'h80));
    tbl.push_back(mk(1,0,1,0,0, 0,0,9,  0,  1,  1,7,1, 32'h80));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,  0,  0,  0,0,0, 32'h0));
    tbl.push_back(mk(1,1,1,0,0, 0,0,0,  0,  1,  0,0,0, 32'h0));
    tbl.push_back(mk(1,1,1,0,0, 0,0,0,  1,  0,  0,0,1, 32'h1));
    tbl.push_back(mk(1,1,1,0,0, 0,0,0,  1,  0,  0,0,1, 32'h1));
    tbl.push_back(mk(1,1,1,0,0, 0,0,0,  1,  0,  0,0,1, 32'h1));

    for (int i = 0; i < tbl.size(); i++)
      run_cycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Reset while two FPU ops are in flight; nothing may write back afterwards
    run_cycle(mk(1,1,1,0,0, 0,0,10, 0,0,0,0,0, 32'h0), 1'b0, "mid0");
    run_cycle(mk(1,1,1,0,0, 0,0,11, 0,0,0,0,0, 32'h0), 1'b0, "mid1");
    chk("mid in_flight before reset", 32'(sb_if.in_flight), 32'd2);
    reset = 1'b0;
    run_cycle(idle, 1'b0, "mid_rst");
    reset = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      run_cycle(idle, 1'b0, $sformatf("post_rst%0d", i));
      chk($sformatf("post_rst%0d no_wb", i), 32'(sb_if.wb_valid), 32'h0);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      x = idle;
      x.v   = ($urandom_range(0, 3) != 0);
      x.fp  = 1'($urandom_range(0, 1));
      x.fwr = x.fp ? 1'b1 : 1'($urandom_range(0, 1));
      x.rsf = 1'($urandom_range(0, 1));
      x.rtf = 1'($urandom_range(0, 1));
      x.rs  = 5'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 31 : 7));
      x.rt  = 5'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 31 : 7));
      x.rd  = 5'($urandom_range(0, ($urandom_range(0, 7) == 0) ? 31 : 7));
      reset = ($urandom_range(0, 199) != 0);
      run_cycle(x, 1'b0, $sformatf("rnd%0d", i));
    end
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
